adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 15 +
 rtl/adder_csel.sv | 81 ++++++++
 rtl/adder_rr_pick.sv | 31 +++
 rtl/adder_arbiter.sv | 164 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder arbiter: FSM state encoding,
// default geometry and the cap on consecutive locked grants.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 32;
    localparam int LOCK_CAP     = 4;

endpackage

// File: rtl/adder_csel.sv
// Gate-level carry-select adder: each BLK-bit block ripples twice (carry-in 0
// and 1) and the incoming block carry picks the precomputed result.
module adder_csel #(
    parameter int W   = 32,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NBLK = (W + BLK - 1) / BLK;
    localparam int WP   = NBLK * BLK;

    logic [WP-1:0]  a_pad;
    logic [WP-1:0]  b_pad;
    logic [WP-1:0]  p_pad;
    logic [WP-1:0]  g_pad;
    logic [BLK-1:0] s0_blk [NBLK];
    logic [BLK-1:0] s1_blk [NBLK];
    logic [NBLK-1:0] co0_blk;
    logic [NBLK-1:0] co1_blk;
    logic [WP-1:0]  s_pad;
    logic           c_sel;
    logic [WP:0]    full;

    assign a_pad = WP'(a);
    assign b_pad = WP'(b);
    assign p_pad = a_pad ^ b_pad;
    assign g_pad = a_pad & b_pad;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            logic [BLK-1:0] pb;
            logic [BLK-1:0] gb;
            logic [BLK-1:0] s0;
            logic [BLK-1:0] s1;
            logic           co0;
            logic           co1;

            assign pb = p_pad[gi*BLK +: BLK];
            assign gb = g_pad[gi*BLK +: BLK];

            always_comb begin
                co0 = 1'b0;
                co1 = 1'b1;
                s0  = '0;
                s1  = '0;
                for (int j = 0; j < BLK; j++) begin
                    s0[j] = pb[j] ^ co0;
                    co0   = gb[j] | (pb[j] & co0);
                    s1[j] = pb[j] ^ co1;
                    co1   = gb[j] | (pb[j] & co1);
                end
            end

            assign s0_blk[gi]  = s0;
            assign s1_blk[gi]  = s1;
            assign co0_blk[gi] = co0;
            assign co1_blk[gi] = co1;
        end
    endgenerate

    // Select chain across blocks; padding bits are zero, so bit W of the
    // padded result is exactly the carry out of bit W-1.
    always_comb begin
        s_pad = '0;
        c_sel = 1'b0;
        for (int bk = 0; bk < NBLK; bk++) begin
            s_pad[bk*BLK +: BLK] = c_sel ? s1_blk[bk] : s0_blk[bk];
            c_sel = co0_blk[bk] | (c_sel & co1_blk[bk]);
        end
    end

    assign full = {c_sel, s_pad};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/adder_rr_pick.sv
// Round-robin picker: scans req_valid starting at pointer p, ascending modulo
// NREQ, and returns a one-hot grant for the first valid requester (or zero).
module adder_rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] p,
    output logic [NREQ-1:0]         grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(p) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_valid[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared adder (IDLE -> EXEC -> HOLD).
// Optional sticky-grant lock enabled by defining ADDER_ARB_LOCK_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [NREQ-1:0]         req_lock,
`endif
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_sum,
    output logic                    rsp_cout,
    input  logic                    rsp_ready
);

    localparam int IDW = $clog2(NREQ);

    state_t          state_reg;
    logic [IDW-1:0]  p_reg;
    logic [IDW-1:0]  p_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IDW-1:0]  id_reg;
    logic            rsp_valid_reg;
    logic [IDW-1:0]  rsp_id_reg;
    logic [W-1:0]    rsp_sum_reg;
    logic            rsp_cout_reg;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  p_inc;
    logic [W-1:0]    a_mask [NREQ];
    logic [W-1:0]    b_mask [NREQ];
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W-1:0]    add_sum;
    logic            add_cout;

    adder_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid (req_valid),
        .p         (p_reg),
        .grant     (grant)
    );

    adder_csel #(.W(W)) u_add (
        .a    (a_reg),
        .b    (b_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_opmux
            assign a_mask[gi] = grant[gi] ? req_a[gi*W +: W] : '0;
            assign b_mask[gi] = grant[gi] ? req_b[gi*W +: W] : '0;
        end
    endgenerate

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel = a_sel | a_mask[i];
            b_sel = b_sel | b_mask[i];
            if (grant[i]) begin
                gnt_idx = IDW'(i);
            end
        end
    end

    assign p_inc = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef ADDER_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_CAP + 1);

    logic [CW-1:0]  lock_cnt_reg;
    logic [CW-1:0]  lock_cnt_next;
    logic [CW-1:0]  lock_cnt_inc;
    logic [IDW-1:0] lock_id_reg;
    logic           lock_hit;

    assign lock_hit     = |(grant & req_lock);
    // A locked streak only continues while the same requester keeps winning.
    assign lock_cnt_inc = (lock_cnt_reg != '0 && lock_id_reg == gnt_idx) ?
                          lock_cnt_reg + CW'(1) : CW'(1);

    always_comb begin
        p_next        = p_inc;
        lock_cnt_next = '0;
        if (lock_hit && lock_cnt_inc < CW'(LOCK_CAP)) begin
            p_next        = gnt_idx;
            lock_cnt_next = lock_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_reg <= '0;
            lock_id_reg  <= '0;
        end else if (state_reg == IDLE && |grant) begin
            lock_cnt_reg <= lock_cnt_next;
            lock_id_reg  <= gnt_idx;
        end
    end
`else
    assign p_next = p_inc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            p_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        a_reg     <= a_sel;
                        b_reg     <= b_sel;
                        id_reg    <= gnt_idx;
                        p_reg     <= p_next;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_reg   <= add_sum;
                    rsp_cout_reg  <= add_cout;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a scoreboard of expected results;
// the lock scenario runs only when ADDER_ARB_LOCK_EN is defined.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
`ifdef ADDER_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock;
`endif
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_ready;

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ADDER_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        logic [1:0] id;
        logic [W:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push at every accept, pop and compare at every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(rsp_id), 64'(e.id));
                    chk("sb_result", 64'({rsp_cout, rsp_sum}), 64'(e.res));
                    $display("rsp    id=%0d sum=%08h cout=%0b", rsp_id, rsp_sum, rsp_cout);
                end
            end
            if (|(req_valid & req_ready)) begin
                exp_t e;
                int   idx;
                logic [W-1:0] a;
                logic [W-1:0] b;
                idx = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) idx = i;
                end
                a     = req_a[idx*W +: W];
                b     = req_b[idx*W +: W];
                e.id  = 2'(idx);
                e.res = {1'b0, a} + {1'b0, b};
                exp_q.push_back(e);
                $display("accept id=%0d a=%08h b=%08h", idx, a, b);
            end
        end
    end

    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid = oh;
        rsp_ready = 1'b1;
        #1 chk("op_ready", 64'(req_ready), 64'(oh));
        tick();
        req_valid = '0;
        req_valid[(i + 1) % NREQ] = 1'b1;
        #1 chk("op_exec_valid", 64'(rsp_valid), 64'd0);
        chk("op_exec_ready", 64'(req_ready), 64'd0);
        tick();
        req_valid = '0;
        #1 chk("op_valid", 64'(rsp_valid), 64'd1);
        chk("op_sum", 64'(rsp_sum), 64'(exp_sum));
        chk("op_cout", 64'(rsp_cout), 64'(exp_cout));
        chk("op_id", 64'(rsp_id), 64'(i));
        tick();
        #1 chk("op_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [NREQ-1:0] e_rdy;
        logic [W:0]      e_res;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef ADDER_ARB_LOCK_EN
        req_lock  = '0;
`endif
        tick();
        req_valid = '1;
        #1 chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1 chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_sum", 64'(rsp_sum), 64'd0);
        chk("rst_cout", 64'(rsp_cout), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        tick();

        // Single request.
        do_op(0, 32'd5, 32'd7, 32'd12, 1'b0);

        // Fairness from a fresh pointer: grants 0,1,2,3,0, one every 3 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 32'(i * 100 + 1);
            req_b[i*W +: W] = 32'(i + 3);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            e_rdy = '0;
            if (k % 3 == 0) e_rdy[(k / 3) % NREQ] = 1'b1;
            #1 chk("fair_ready", 64'(req_ready), 64'(e_rdy));
            tick();
        end
        req_valid = '0;
        tick();

        // Wrap-around cases; pointer now sits at 1.
        do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        do_op(3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

        // Backpressure: all valid, pointer at 0, consumer stalls 10 cycles.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 32'hF000_0000 + 32'(i);
            req_b[i*W +: W] = 32'h1234_5678;
        end
        e_res     = {1'b0, 32'hF000_0000} + {1'b0, 32'h1234_5678};
        rsp_ready = 1'b0;
        req_valid = '1;
        #1 chk("bp_grant", 64'(req_ready), 64'b0001);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            #1 chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_result", 64'({rsp_cout, rsp_sum}), 64'(e_res));
            chk("bp_id", 64'(rsp_id), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_valid", 64'(rsp_valid), 64'd1);
        tick();
        #1 chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
        chk("bp_idle_ready", 64'(req_ready), 64'b0010);
        req_valid = '0;
        #1 chk("withdraw_ready", 64'(req_ready), 64'd0);
        tick();
        #1 chk("withdraw_valid", 64'(rsp_valid), 64'd0);

        // Withdrawn request left the pointer alone; then reset while in HOLD.
        rsp_ready = 1'b0;
        req_valid = '1;
        #1 chk("withdraw_grant", 64'(req_ready), 64'b0010);
        tick();
        tick();
        #1 chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_id", 64'(rsp_id), 64'd1);
        rst = 1'b1;
        #1 chk("hold_rst_ready", 64'(req_ready), 64'd0);
        tick();
        #1 chk("hold_rst_valid", 64'(rsp_valid), 64'd0);
        chk("hold_rst_sum", 64'(rsp_sum), 64'd0);
        rst = 1'b0;
        #1 chk("post_rst_grant", 64'(req_ready), 64'b0001);
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        #1 chk("post_rst_rsp", 64'(rsp_valid), 64'd1);
        chk("post_rst_id", 64'(rsp_id), 64'd0);
        tick();
        tick();

`ifdef ADDER_ARB_LOCK_EN
        // Lock on requester 0 with 1 also pending: grants 0,0,0,0,1.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b0011;
        req_lock  = 4'b0001;
        rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            e_rdy = '0;
            if (k % 3 == 0) e_rdy = (k / 3 < 4) ? 4'b0001 : 4'b0010;
            #1 chk("lock_ready", 64'(req_ready), 64'(e_rdy));
            tick();
        end
        req_valid = '0;
        req_lock  = '0;
        tick();
        tick();
`endif

        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
